// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-high
// hex glyph table ({g,f,e,d,c,b,a}) and the all-segments-off code.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decode, active-high output.
// A blanked digit decodes to SEG_OFF regardless of the nibble.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_OFF : SEG_CODE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free frame updates.
// Define SEG_LZ_BLANK_EN to enable leading-zero blanking via blank_lz.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int SEL_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done,
  output logic                  upd_pending
);

  localparam int              IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(SCAN_DIV - 1);
  localparam logic            SEL_INV  = (SEL_ACT_LOW != 0);
  localparam logic            SEG_INV  = (SEG_ACT_LOW != 0);

  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_pend_data;
  logic [DIGITS-1:0]     r_pend_dp;
  logic [4*DIGITS-1:0]   r_shd_data;
  logic [DIGITS-1:0]     r_shd_dp;
  logic                  r_upd_pending;
  logic                  r_frame_done;
  logic [DIGITS-1:0]     r_sel;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_commit;
  logic [IW-1:0]         w_idx_next;
  logic [4*DIGITS-1:0]   w_shd_data_next;
  logic [DIGITS-1:0]     w_shd_dp_next;
  logic [DIGITS-1:0]     w_sel_onehot;
  logic [3:0]            w_nibble;
  logic                  w_dp_bit;
  logic                  w_blank;
  logic [6:0]            w_seg_code;

  assign w_tick     = en && (r_count == LAST_CNT);
  assign w_boundary = w_tick && (r_idx == LAST_IDX);
  // Paused scanning has no frame to tear, so the shadow follows pending directly.
  assign w_commit   = w_boundary || !en;
  assign w_idx_next = !w_tick ? r_idx : (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

  // A load in the commit cycle bypasses pending so the newest data wins.
  assign w_shd_data_next = !w_commit ? r_shd_data : load ? disp_data : r_pend_data;
  assign w_shd_dp_next   = !w_commit ? r_shd_dp   : load ? dp_in     : r_pend_dp;

  // Outputs are registered from next-state values so they change with idx.
  assign w_sel_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_next;
  assign w_nibble     = w_shd_data_next[{w_idx_next, 2'b00} +: 4];
  assign w_dp_bit     = w_shd_dp_next[w_idx_next];

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] w_lz_mask;
  logic              w_zero_run;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_lz_mask  = '0;
    w_zero_run = blank_lz;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_run   = w_zero_run && (w_shd_data_next[4*k +: 4] == 4'h0) && !w_shd_dp_next[k];
      w_lz_mask[k] = w_zero_run;
    end
  end

  assign w_blank = w_lz_mask[w_idx_next];
`else
  logic w_unused_blank_lz;
  assign w_unused_blank_lz = blank_lz;
  assign w_blank           = 1'b0;
`endif

  seg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg_code)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_count       <= '0;
      r_idx         <= '0;
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_shd_data    <= '0;
      r_shd_dp      <= '0;
      r_upd_pending <= 1'b0;
      r_frame_done  <= 1'b0;
      r_sel         <= {DIGITS{SEL_INV}};
      r_seg         <= SEG_OFF ^ {7{SEG_INV}};
      r_dp          <= SEG_INV;
    end else begin
      if (en) begin
        r_count <= w_tick ? '0 : r_count + 1'b1;
      end
      r_idx <= w_idx_next;
      if (load) begin
        r_pend_data <= disp_data;
        r_pend_dp   <= dp_in;
      end
      r_shd_data    <= w_shd_data_next;
      r_shd_dp      <= w_shd_dp_next;
      r_upd_pending <= w_commit ? 1'b0 : (load || r_upd_pending);
      r_frame_done  <= w_boundary;
      if (en) begin
        r_sel <= w_sel_onehot ^ {DIGITS{SEL_INV}};
        r_seg <= w_seg_code ^ {7{SEG_INV}};
        r_dp  <= w_dp_bit ^ SEG_INV;
      end else begin
        r_sel <= {DIGITS{SEL_INV}};
        r_seg <= SEG_OFF ^ {7{SEG_INV}};
        r_dp  <= SEG_INV;
      end
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign sel         = r_sel;
  assign frame_done  = r_frame_done;
  assign upd_pending = r_upd_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=8, SCAN_DIV=4, active-low).
// Honours SEG_LZ_BLANK_EN when the same macro is set for the build.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  localparam logic [6:0] HEX_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] EXP_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n, en, load, blank_lz;
  logic [31:0] disp_data;
  logic [7:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  sel;
  logic        frame_done, upd_pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (DIV),
    .SEL_ACT_LOW (1),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .disp_data   (disp_data),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .sel         (sel),
    .frame_done  (frame_done),
    .upd_pending (upd_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle count n gives slot and frame position arithmetically.
  int          m_n;
  int          m_k;
  logic [31:0] m_pend, m_shd;
  logic [7:0]  m_pdp, m_sdp;
  logic        m_upd, m_fd, m_dp;
  logic [7:0]  m_sel;
  logic [6:0]  m_seg;
  bit          chk_en = 1'b0;

  function automatic logic [7:0] exp_view(input logic [31:0] d, input logic [7:0] p,
                                          input int k, input logic bl);
    logic blanked;
    blanked = LZ_ON && bl && (k != 0) && ((d >> (4*k)) == 0) && ((p >> k) == 0);
    return {(blanked ? 7'h7F : ~HEX_HI[d[4*k +: 4]]), ~p[k]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_pend = '0; m_pdp = '0; m_shd = '0; m_sdp = '0;
      m_upd = 1'b0; m_fd = 1'b0;
      m_sel = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_fd = en && ((m_n % FRAME) == FRAME - 1);
      if (load) begin
        m_pend = disp_data;
        m_pdp  = dp_in;
      end
      if (!en || m_fd) begin
        m_shd = m_pend;
        m_sdp = m_pdp;
        m_upd = 1'b0;
      end else if (load) begin
        m_upd = 1'b1;
      end
      if (en) begin
        m_n++;
        m_k   = (m_n / DIV) % DIGITS;
        m_sel = ~(8'h01 << m_k);
        {m_seg, m_dp} = exp_view(m_shd, m_sdp, m_k, blank_lz);
      end else begin
        m_sel = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel", sel, m_sel);
      check("model_seg", seg, m_seg);
      check("model_dp", dp, m_dp);
      check("model_frame_done", frame_done, m_fd);
      check("model_upd_pending", upd_pending, m_upd);
    end
  end

  task automatic wait_sel(input logic [7:0] v);
    int t = 0;
    while (sel == v && t < 200) begin @(negedge clk); t++; end
    while (sel != v && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_vec++; n_err++;
      $display("FAIL wait_sel timeout: sel=%0h wanted %0h", sel, v);
    end
  endtask

  task automatic wait_fd();
    int t = 0;
    while (!frame_done && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_vec++; n_err++;
      $display("FAIL wait_fd timeout: frame_done=%0b expected 1", frame_done);
    end
  endtask

  task automatic lz_frame(input logic [31:0] d, input logic [6:0] exp_seg [8]);
    @(negedge clk);
    en = 1'b0; load = 1'b1; disp_data = d; dp_in = '0; blank_lz = 1'b1;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < DIGITS; k++) begin
        if (!sel[k]) check($sformatf("lz_digit%0d", k), seg, exp_seg[k]);
      end
    end
  endtask

  typedef struct {
    logic [3:0] nib;
    logic       dpb;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int c;
    logic [6:0] lz_a [8];
    logic [6:0] lz_z [8];

    for (int i = 0; i < 16; i++) begin
      tbl[i].nib     = 4'(i);
      tbl[i].dpb     = 1'(i % 2);
      tbl[i].exp_seg = EXP_AL[i];
      tbl[i].exp_dp  = ~tbl[i].dpb;
    end

    rst_n = 1'b0; en = 1'b0; load = 1'b0; blank_lz = 1'b0;
    disp_data = '0; dp_in = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_sel", sel, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_upd_pending", upd_pending, 1'b0);
    rst_n = 1'b1;

    // Full hex decode and dp polarity, all digits carrying the same nibble.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en = 1'b0; load = 1'b1;
      disp_data = {8{tbl[i].nib}}; dp_in = {8{tbl[i].dpb}};
      @(negedge clk);
      load = 1'b0; en = 1'b1;
      @(negedge clk);
      check($sformatf("hex_seg_%0h", tbl[i].nib), seg, tbl[i].exp_seg);
      check($sformatf("hex_dp_%0h", tbl[i].nib), dp, tbl[i].exp_dp);
    end

    // Scan rotation and frame period.
    @(negedge clk);
    load = 1'b1; disp_data = 32'h0123_4567; dp_in = '0;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    check("scan_d0_sel", sel, 8'hFE);
    check("scan_d0_seg", seg, 7'h78);
    repeat (DIV) @(negedge clk);
    check("scan_d1_sel", sel, 8'hFD);
    check("scan_d1_seg", seg, 7'h02);
    c = DIV;
    while (!frame_done && c < 64) begin @(negedge clk); c++; end
    check("frame_period", c, FRAME);

    // Tear-free update loaded mid-frame at digit 3.
    wait_sel(8'hF7);
    load = 1'b1; disp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    load = 1'b0;
    check("tear_upd_pending", upd_pending, 1'b1);
    wait_sel(8'hEF);
    check("tear_old_d4_seg", seg, 7'h30);
    wait_fd();
    check("tear_upd_cleared", upd_pending, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      check("tear_new_seg", seg, 7'h0E);
      @(negedge clk);
    end

    // Pause one cycle into digit 5; prescaler must hold its value.
    wait_sel(8'hDF);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("pause_sel_off", sel, 8'hFF);
    check("pause_seg_off", seg, 7'h7F);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("resume_sel", sel, 8'hDF);
    c = 1;
    while (c < 10) begin
      @(negedge clk);
      if (sel != 8'hDF) break;
      c++;
    end
    check("resume_slot_len", c, DIV - 2);

    // Load coinciding with the frame boundary goes straight to the shadow.
    wait_sel(8'h7F);
    repeat (DIV - 1) @(negedge clk);
    load = 1'b1; disp_data = 32'h89AB_CDEF;
    @(negedge clk);
    load = 1'b0;
    check("coinc_frame_done", frame_done, 1'b1);
    check("coinc_sel", sel, 8'hFE);
    check("coinc_seg", seg, 7'h0E);
    for (int i = 0; i < FRAME; i++) begin
      check("coinc_upd_low", upd_pending, 1'b0);
      @(negedge clk);
    end

    // Reset mid-frame discards pending data and restarts at digit 0.
    load = 1'b1; disp_data = 32'h5555_5555;
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sel", sel, 8'hFF);
    check("midrst_upd", upd_pending, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_restart_sel", sel, 8'hFE);
    check("midrst_restart_seg", seg, 7'h40);
    wait_fd();
    check("midrst_no_stale_seg", seg, 7'h40);

    // Leading-zero blanking request.
    lz_a = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    lz_z = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    if (LZ_ON) begin
      for (int k = 3; k < DIGITS; k++) lz_a[k] = 7'h7F;
      for (int k = 1; k < DIGITS; k++) lz_z[k] = 7'h7F;
    end
    lz_frame(32'h0000_0A05, lz_a);
    lz_frame(32'h0000_0000, lz_z);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 599) != 0);
      en        = ($urandom_range(0, 9) != 0);
      load      = ($urandom_range(0, 15) == 0);
      disp_data = $urandom >> $urandom_range(0, 31);
      dp_in     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      blank_lz  = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, range 2..16.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-003 Parameter SEL_ACT_LOW, default 1: 1 means the active sel bit is driven 0.
REQ-004 Parameter SEG_ACT_LOW, default 1: 1 means lit seg/dp bits are driven 0.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  scan enable.
REQ-008 load  in  1  single-cycle strobe that captures disp_data and dp_in.
REQ-009 disp_data  in  4*DIGITS  hex nibbles; nibble 0 is the least-significant digit.
REQ-010 dp_in  in  DIGITS  per-digit decimal point request.
REQ-011 blank_lz  in  1  leading-zero blanking request.
REQ-012 seg  out  7  segment drive {g,f,e,d,c,b,a}, registered.
REQ-013 dp  out  1  decimal point drive, registered.
REQ-014 sel  out  DIGITS  one-hot digit select, registered.
REQ-015 frame_done  out  1  one-cycle pulse at end of each frame.
REQ-016 upd_pending  out  1  high while loaded data awaits the frame boundary.

Function
REQ-017 Prescaler shall count 0..SCAN_DIV-1 while en=1; tick = (count==SCAN_DIV-1); count wraps to 0.
REQ-018 Digit index idx shall increment on tick and wrap from DIGITS-1 to 0.
REQ-019 Boundary = tick AND idx==DIGITS-1; frame_done shall be 1 in the cycle after the boundary, for exactly one cycle.
REQ-020 load shall capture disp_data/dp_in into a pending register and set upd_pending.
REQ-021 At a boundary the pending register shall copy into the display shadow and clear upd_pending; a frame never mixes old and new data.
REQ-022 When load and boundary coincide, the new load data shall go directly to the shadow and upd_pending shall stay 0.
REQ-023 A second load before the boundary shall overwrite pending; the last value wins.
REQ-024 While en=0: prescaler and idx hold; sel all inactive; seg/dp off; pending still accepts load; shadow takes pending immediately.
REQ-025 sel, seg and dp shall update together exactly one cycle after tick (or after en rises) and reflect the new idx.
REQ-026 Hex decode shall be full 0-F, active-high codes 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71, inverted when SEG_ACT_LOW=1.
REQ-027 dp shall be lit when the shadow dp bit of the current digit is 1.

Reset
REQ-028 With rst_n=0 at an edge: count=0, idx=0, pending=0, shadow=0, upd_pending=0, frame_done=0, sel all inactive, seg/dp off.
REQ-029 Reset mid-frame shall abandon the frame and any pending data; scanning restarts at digit 0 after release.

Configuration
REQ-030 With SEG_LZ_BLANK_EN defined and blank_lz=1: digit k is blanked (seg off, sel still active) if nibbles DIGITS-1..k are all 0 and no dp bit in that range is set; digit 0 is never blanked.
REQ-031 Without SEG_LZ_BLANK_EN, blank_lz shall be ignored and all digits shall display.

Structure
REQ-032 Package seg_pkg shall hold the 16-entry active-high segment code constants and the SEG_OFF constant.
REQ-033 The combinational nibble-to-segment decode shall be sub-module seg_hex_decode; everything else lives in seg_scan_ctrl.

Verification (DIGITS=8, SCAN_DIV=4, active-low)
REQ-034 Reset: rst_n=0 for 2 cycles -> sel=8'hFF, seg=7'h7F, dp=1, frame_done=0.
REQ-035 Scan: en=1, load 32'h01234567 -> after first boundary, digit 0 shows seg=7'h78 with sel=8'hFE; sel rotates every 4 cycles; frame_done every 32 cycles.
REQ-036 Tear-free: load 32'hFFFFFFFF at idx=3 -> rest of frame unchanged, upd_pending=1; next frame all digits seg=7'h0E, upd_pending=0.
REQ-037 Leading zeros (macro on, blank_lz=1): load 32'h00000A05 -> digits 7..3 seg=7'h7F, digit 2 seg=7'h08, digit 1 seg=7'h40; all-zero data -> only digit 0 shows 7'h40.
REQ-038 Pause: en=0 at idx=5 -> sel=8'hFF the next cycle; en=1 -> resumes at idx=5 with the prescaler value held.
REQ-039 Coincident load and boundary -> next frame shows new data, upd_pending never rises.
